// File: rtl/wb_regfile_pkg.sv
// Pipeline buffer types shared across stages: MEM/WB bundle and
// writeback-select encodings.
package Pipe_Buf_Reg_PKG;

    localparam int XLEN_W = 32;

    typedef enum logic [1:0] {
        WB_ALU_MEM = 2'b00,
        WB_PC4     = 2'b01,
        WB_IMM     = 2'b10,
        WB_PCIMM   = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic              RegWrite;
        logic              MemtoReg;
        logic [XLEN_W-1:0] Pc_Imm;
        logic [XLEN_W-1:0] Pc_Four;
        logic [XLEN_W-1:0] Imm_Out;
        logic [XLEN_W-1:0] Alu_Result;
        logic [XLEN_W-1:0] MemReadData;
        logic [4:0]        rd;
        logic [XLEN_W-1:0] Curr_Instr;
        wb_sel_e           RWSel;
    } mem_wb_reg;

endpackage

// File: rtl/wb_regfile_mux.sv
// Writeback value selection from the MEM/WB bundle.
module wb_mux
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int XLEN = 32
) (
    input  mem_wb_reg        wb_in,
    output logic [XLEN-1:0]  wb_data
);

    always_comb begin
        wb_data = wb_in.Alu_Result;
        unique case (wb_in.RWSel)
            WB_ALU_MEM: wb_data = wb_in.MemtoReg ? wb_in.MemReadData
                                                 : wb_in.Alu_Result;
            WB_PC4:     wb_data = wb_in.Pc_Four;
            WB_IMM:     wb_data = wb_in.Imm_Out;
            WB_PCIMM:   wb_data = wb_in.Pc_Imm;
            default:    wb_data = wb_in.Alu_Result;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural register file with read bypass.
// Optional retire trace ports enabled by defining WB_TRACE_EN.
module wb_regfile
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  mem_wb_reg       wb_in,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_we
`ifdef WB_TRACE_EN
    ,
    output logic [31:0]     retire_cnt,
    output logic [31:0]     last_instr
`endif
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    wb_mux #(.XLEN(XLEN)) u_wb_mux (
        .wb_in   (wb_in),
        .wb_data (wb_data)
    );

    assign wb_rd = wb_in.rd;
    assign wb_we = wb_in.RegWrite && (wb_in.rd != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wb_we) regs_d[wb_rd] = wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 reads zero; a pending write to the same register wins.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0) begin
            if (wb_we && rs1_addr == wb_rd) rs1_data = wb_data;
            else                            rs1_data = regs_q[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != 5'd0) begin
            if (wb_we && rs2_addr == wb_rd) rs2_data = wb_data;
            else                            rs2_data = regs_q[rs2_addr];
        end
    end

`ifdef WB_TRACE_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] last_instr_q, last_instr_d;

    // A zero instruction word is a bubble and does not retire.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        last_instr_d = last_instr_q;
        if (wb_in.Curr_Instr != 32'd0) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
            last_instr_d = wb_in.Curr_Instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt_q <= '0;
            last_instr_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            last_instr_q <= last_instr_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign last_instr = last_instr_q;
`else
    logic unused_instr;
    assign unused_instr = ^wb_in.Curr_Instr;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;
    import Pipe_Buf_Reg_PKG::*;

    logic        clk = 1'b0;
    logic        reset;
    mem_wb_reg   wb_in;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic [4:0]  wb_rd;
    logic        wb_we;
`ifdef WB_TRACE_EN
    logic [31:0] retire_cnt, last_instr;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(32), .NREG(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_in    (wb_in),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_data  (wb_data),
        .wb_rd    (wb_rd),
        .wb_we    (wb_we)
`ifdef WB_TRACE_EN
        ,
        .retire_cnt (retire_cnt),
        .last_instr (last_instr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wb_in = '0;
        wb_in.MemReadData = 32'hAAAA_0001;
        wb_in.Imm_Out     = 32'h0000_0800;
        wb_in.Pc_Imm      = 32'h0000_0040;
        wb_in.Pc_Four     = 32'h0000_0104;
        wb_in.RWSel       = WB_ALU_MEM;
    endtask

    task automatic wr(input logic [4:0] rd, input wb_sel_e sel,
                      input logic m2r, input logic [31:0] alu);
        idle();
        wb_in.RegWrite   = 1'b1;
        wb_in.rd         = rd;
        wb_in.RWSel      = sel;
        wb_in.MemtoReg   = m2r;
        wb_in.Alu_Result = alu;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rs1_addr = '0;
        rs2_addr = '0;
        #12;
        check("rst_we", {31'd0, wb_we}, 32'd0);
        rs1_addr = 5'd5;
        #1;
        check("rst_x5", rs1_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ALU write then read
        wr(5'd5, WB_ALU_MEM, 1'b0, 32'h1234_5678);
        #1;
        check("alu_we", {31'd0, wb_we}, 32'd1);
        check("alu_wbd", wb_data, 32'h1234_5678);
        check("alu_rd", {27'd0, wb_rd}, 32'd5);
        @(negedge clk);
        idle();
        rs1_addr = 5'd5;
        #1;
        check("alu_rs1", rs1_data, 32'h1234_5678);

        // same-cycle bypass, both ports
        wr(5'd7, WB_PC4, 1'b0, 32'h0);
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        #1;
        check("byp_rs1", rs1_data, 32'h0000_0104);
        check("byp_rs2", rs2_data, 32'h0000_0104);
        @(negedge clk);
        idle();
        #1;
        check("byp_st", rs1_data, 32'h0000_0104);

        // x0 protection
        wr(5'd0, WB_ALU_MEM, 1'b0, 32'hDEAD_BEEF);
        rs1_addr = 5'd0;
        #1;
        check("x0_we", {31'd0, wb_we}, 32'd0);
        check("x0_wbd", wb_data, 32'hDEAD_BEEF);
        check("x0_pre", rs1_data, 32'd0);
        @(negedge clk);
        #1;
        check("x0_post", rs1_data, 32'd0);

        // selection sweep
        @(negedge clk);
        wr(5'd1, WB_ALU_MEM, 1'b1, 32'h5555_5555);
        @(negedge clk);
        wr(5'd2, WB_IMM, 1'b0, 32'h5555_5555);
        @(negedge clk);
        wr(5'd3, WB_PCIMM, 1'b0, 32'h5555_5555);
        @(negedge clk);
        idle();
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        #1;
        check("sel_x1", rs1_data, 32'hAAAA_0001);
        check("sel_x2", rs2_data, 32'h0000_0800);
        rs1_addr = 5'd3;
        #1;
        check("sel_x3", rs1_data, 32'h0000_0040);

        // one port bypassed, the other reads stored x3
        wr(5'd3, WB_ALU_MEM, 1'b0, 32'h0BAD_F00D);
        rs1_addr = 5'd3;
        rs2_addr = 5'd5;
        #1;
        check("byp1_rs1", rs1_data, 32'h0BAD_F00D);
        check("byp1_rs2", rs2_data, 32'h1234_5678);

        // mid-run async reset with a write pending to x9
        @(negedge clk);
        wr(5'd9, WB_ALU_MEM, 1'b0, 32'hCAFE_0009);
        rs1_addr = 5'd5;
        rs2_addr = 5'd9;
        #2;
        reset = 1'b1;
        #1;
        check("mr_x5", rs1_data, 32'd0);
        check("mr_byp", rs2_data, 32'hCAFE_0009);
        check("mr_wbd", wb_data, 32'hCAFE_0009);
        @(negedge clk);
        @(negedge clk);
        idle();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check($sformatf("mr_r1_x%0d", i), rs1_data, 32'd0);
            check($sformatf("mr_r2_x%0d", 31 - i), rs2_data, 32'd0);
        end

        // first write after reset lands on the first edge
        @(negedge clk);
        wr(5'd4, WB_ALU_MEM, 1'b0, 32'h0000_0044);
        @(negedge clk);
        idle();
        rs1_addr = 5'd4;
        #1;
        check("post_wr", rs1_data, 32'h0000_0044);

`ifdef WB_TRACE_EN
        reset = 1'b1;
        #1;
        check("tr_rcnt0", retire_cnt, 32'd0);
        check("tr_last0", last_instr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wb_in.Curr_Instr = 32'h0000_0013;
        @(negedge clk);
        wb_in.Curr_Instr = 32'h0010_0093;
        wb_in.RegWrite   = 1'b1;
        wb_in.rd         = 5'd1;
        @(negedge clk);
        wb_in.Curr_Instr = 32'h0020_0113;
        wb_in.RegWrite   = 1'b0;
        @(negedge clk);
        wb_in.Curr_Instr = 32'h0;
        @(negedge clk);
        wb_in.Curr_Instr = 32'h0030_0193;
        @(negedge clk);
        wb_in.Curr_Instr = 32'h0;
        #1;
        check("tr_cnt4", retire_cnt, 32'd4);
        check("tr_last", last_instr, 32'h0030_0193);
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        wb_in.Curr_Instr = 32'h0040_0213;
        @(negedge clk);
        wb_in.Curr_Instr = 32'h0;
        #1;
        check("tr_wrap", retire_cnt, 32'd0);
        check("tr_last2", last_instr, 32'h0040_0213);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
